// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------
// Central stall/flush controller for the 5-stage pipeline. It drives the
// enable and active-low clear of every pipeline register plus the PC enable.
// It resolves load-use hazards, taken-branch flushes and multi-cycle
// data-memory waits. It also keeps saturating stall/flush counters and a
// sticky memory-wait watchdog.
//
// Handshake note: there is no valid/ready pair here. Mem_Req/Mem_Ready
// behave as a request/complete pair. A cycle with Mem_Req=1 and Mem_Ready=0
// is a wait cycle. A cycle with Mem_Req=1 and Mem_Ready=1 completes the
// access and lets the pipeline advance.
//
// Ports:
//   clk, clr            clock, synchronous active-high reset
//   Ex_Mem2reg, Ex_Rd   load-in-EX flag and its destination register
//   Id_Rs, Id_Rt        ID source registers
//   Id_UsesRt           ID instruction reads Rt
//   Ex_Branch_Taken     branch resolved taken in EX
//   Mem_Req, Mem_Ready  data-memory request / completion
//   Pc_en, *_en, *_clr_n  pipeline control (combinational)
//   Stall_Cnt, Flush_Cnt  saturating performance counters
//   Mem_Timeout         sticky watchdog flag
//   dbg_state           current FSM state (0 = RUN, 1 = MWAIT)

module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             Ex_Mem2reg,
   input  logic [4:0]       Ex_Rd,
   input  logic [4:0]       Id_Rs,
   input  logic [4:0]       Id_Rt,
   input  logic             Id_UsesRt,
   input  logic             Ex_Branch_Taken,
   input  logic             Mem_Req,
   input  logic             Mem_Ready,
   output logic             Pc_en,
   output logic             IfId_en,
   output logic             IfId_clr_n,
   output logic             IdEx_en,
   output logic             IdEx_clr_n,
   output logic             ExMem_en,
   output logic             ExMem_clr_n,
   output logic             MemWb_en,
   output logic             MemWb_clr_n,
   output logic [CNT_W-1:0] Stall_Cnt,
   output logic [CNT_W-1:0] Flush_Cnt,
   output logic             Mem_Timeout,
   output logic             dbg_state
);

   typedef enum logic {
      RUN   = 1'b0,
      MWAIT = 1'b1
   } state_t;

   localparam int               WAIT_W   = 16;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic               timeout_q, timeout_d;

   logic               mem_wait;
   logic               load_use;

   // Hazard decode. Register 0 is hard-wired zero, so it never creates a
   // real dependence.
   assign mem_wait = Mem_Req & ~Mem_Ready;
   assign load_use = Ex_Mem2reg && (Ex_Rd != 5'd0) &&
                     ((Ex_Rd == Id_Rs) || (Id_UsesRt && (Ex_Rd == Id_Rt)));

   // State register
   always_ff @(posedge clk) begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      timeout_q   <= timeout_d;
   end

   // Next-state logic. The priority order is clr, memory wait, branch,
   // load-use. The MWAIT state needs no special exit handling: the cycle
   // that ends a wait is decoded like any RUN cycle.
   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      timeout_d   = timeout_q;
      if (clr) begin
         state_d     = RUN;
         wait_cnt_d  = '0;
         stall_cnt_d = '0;
         flush_cnt_d = '0;
         timeout_d   = 1'b0;
      end else if (mem_wait) begin
         state_d = MWAIT;
         if (wait_cnt_q != WAIT_MAX)
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
         if (stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         // Sticky: once set, the flag is only cleared by clr.
         if (wait_cnt_d == WAIT_MAX)
            timeout_d = 1'b1;
      end else begin
         state_d    = RUN;
         wait_cnt_d = '0;
         if (Ex_Branch_Taken) begin
            if (flush_cnt_q != CNT_MAX)
               flush_cnt_d = flush_cnt_q + CNT_W'(1);
         end else if (load_use) begin
            if (stall_cnt_q != CNT_MAX)
               stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end
      end
   end

   // Output logic. Pipeline registers let en=0 override clr_n=0, so every
   // frozen register is given clr_n=1 to keep the intent unambiguous.
   always_comb begin
      Pc_en       = 1'b1;
      IfId_en     = 1'b1;
      IfId_clr_n  = 1'b1;
      IdEx_en     = 1'b1;
      IdEx_clr_n  = 1'b1;
      ExMem_en    = 1'b1;
      ExMem_clr_n = 1'b1;
      MemWb_en    = 1'b1;
      MemWb_clr_n = 1'b1;
      if (clr) begin
         IfId_clr_n  = 1'b0;
         IdEx_clr_n  = 1'b0;
         ExMem_clr_n = 1'b0;
         MemWb_clr_n = 1'b0;
      end else if (mem_wait) begin
         // Freeze everything up to MEM. A bubble goes into WB so the
         // instruction in MEM is not written back twice.
         Pc_en       = 1'b0;
         IfId_en     = 1'b0;
         IdEx_en     = 1'b0;
         ExMem_en    = 1'b0;
         MemWb_clr_n = 1'b0;
      end else if (Ex_Branch_Taken) begin
         // Squash the two wrong-path instructions. The PC loads the target.
         IfId_clr_n = 1'b0;
         IdEx_clr_n = 1'b0;
      end else if (load_use) begin
         // Hold IF/ID for one cycle and inject a bubble into EX.
         Pc_en      = 1'b0;
         IfId_en    = 1'b0;
         IdEx_clr_n = 1'b0;
      end
   end

   assign Stall_Cnt   = stall_cnt_q;
   assign Flush_Cnt   = flush_cnt_q;
   assign Mem_Timeout = timeout_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Three instances share one set of
// inputs. The first uses the default parameters, the second MEM_TIMEOUT=4
// for the watchdog, and the third CNT_W=4 for counter saturation. Inputs
// change at the falling edge. Every check is made 1 time unit later, so the
// combinational controls reflect the current inputs and the registered
// outputs reflect all previous rising edges.

module tb_pipe_hazard_ctrl;

   // Control vector order:
   // {Pc, IfId en/clr_n, IdEx en/clr_n, ExMem en/clr_n, MemWb en/clr_n}
   localparam logic [8:0] C_RESET  = 9'b1_10_10_10_10;
   localparam logic [8:0] C_WAIT   = 9'b0_01_01_01_10;
   localparam logic [8:0] C_BRANCH = 9'b1_10_10_11_11;
   localparam logic [8:0] C_LU     = 9'b0_01_10_11_11;
   localparam logic [8:0] C_NORM   = 9'b1_11_11_11_11;

   logic       clk = 1'b0;
   logic       clr;
   logic       ex_mem2reg;
   logic [4:0] ex_rd, id_rs, id_rt;
   logic       id_uses_rt, ex_branch_taken, mem_req, mem_ready;

   logic        pc_en [3];
   logic        ifid_en [3], ifid_clr_n [3], idex_en [3], idex_clr_n [3];
   logic        exmem_en [3], exmem_clr_n [3], memwb_en [3], memwb_clr_n [3];
   logic        mem_timeout [3];
   logic        dbg_state [3];
   logic [15:0] stall_a, flush_a, stall_w, flush_w;
   logic [3:0]  stall_s, flush_s;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk(clk), .clr(clr), .Ex_Mem2reg(ex_mem2reg), .Ex_Rd(ex_rd),
      .Id_Rs(id_rs), .Id_Rt(id_rt), .Id_UsesRt(id_uses_rt),
      .Ex_Branch_Taken(ex_branch_taken), .Mem_Req(mem_req), .Mem_Ready(mem_ready),
      .Pc_en(pc_en[0]), .IfId_en(ifid_en[0]), .IfId_clr_n(ifid_clr_n[0]),
      .IdEx_en(idex_en[0]), .IdEx_clr_n(idex_clr_n[0]),
      .ExMem_en(exmem_en[0]), .ExMem_clr_n(exmem_clr_n[0]),
      .MemWb_en(memwb_en[0]), .MemWb_clr_n(memwb_clr_n[0]),
      .Stall_Cnt(stall_a), .Flush_Cnt(flush_a),
      .Mem_Timeout(mem_timeout[0]), .dbg_state(dbg_state[0])
   );

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut_wd (
      .clk(clk), .clr(clr), .Ex_Mem2reg(ex_mem2reg), .Ex_Rd(ex_rd),
      .Id_Rs(id_rs), .Id_Rt(id_rt), .Id_UsesRt(id_uses_rt),
      .Ex_Branch_Taken(ex_branch_taken), .Mem_Req(mem_req), .Mem_Ready(mem_ready),
      .Pc_en(pc_en[1]), .IfId_en(ifid_en[1]), .IfId_clr_n(ifid_clr_n[1]),
      .IdEx_en(idex_en[1]), .IdEx_clr_n(idex_clr_n[1]),
      .ExMem_en(exmem_en[1]), .ExMem_clr_n(exmem_clr_n[1]),
      .MemWb_en(memwb_en[1]), .MemWb_clr_n(memwb_clr_n[1]),
      .Stall_Cnt(stall_w), .Flush_Cnt(flush_w),
      .Mem_Timeout(mem_timeout[1]), .dbg_state(dbg_state[1])
   );

   pipe_hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(4)) dut_sat (
      .clk(clk), .clr(clr), .Ex_Mem2reg(ex_mem2reg), .Ex_Rd(ex_rd),
      .Id_Rs(id_rs), .Id_Rt(id_rt), .Id_UsesRt(id_uses_rt),
      .Ex_Branch_Taken(ex_branch_taken), .Mem_Req(mem_req), .Mem_Ready(mem_ready),
      .Pc_en(pc_en[2]), .IfId_en(ifid_en[2]), .IfId_clr_n(ifid_clr_n[2]),
      .IdEx_en(idex_en[2]), .IdEx_clr_n(idex_clr_n[2]),
      .ExMem_en(exmem_en[2]), .ExMem_clr_n(exmem_clr_n[2]),
      .MemWb_en(memwb_en[2]), .MemWb_clr_n(memwb_clr_n[2]),
      .Stall_Cnt(stall_s), .Flush_Cnt(flush_s),
      .Mem_Timeout(mem_timeout[2]), .dbg_state(dbg_state[2])
   );

   function automatic logic [8:0] ctrl(input int i);
      return {pc_en[i], ifid_en[i], ifid_clr_n[i], idex_en[i], idex_clr_n[i],
              exmem_en[i], exmem_clr_n[i], memwb_en[i], memwb_clr_n[i]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Wait for the falling edge, apply the inputs, then let them settle.
   task automatic cyc(input logic c, input logic m2r, input logic [4:0] rd,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic br, input logic req, input logic rdy);
      @(negedge clk);
      clr = c; ex_mem2reg = m2r; ex_rd = rd; id_rs = rs; id_rt = rt;
      id_uses_rt = urt; ex_branch_taken = br; mem_req = req; mem_ready = rdy;
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mwait();
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      clr = 1'b1; ex_mem2reg = 1'b0; ex_rd = '0; id_rs = '0; id_rt = '0;
      id_uses_rt = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;

      // Reset held for two cycles with random inputs
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("reset_ctrl", 32'(ctrl(0)), 32'(C_RESET));
      end
      idle();
      check("rst_stall", 32'(stall_a), 0);
      check("rst_flush", 32'(flush_a), 0);
      check("rst_timeout", 32'(mem_timeout[0]), 0);
      check("rst_state", 32'(dbg_state[0]), 0);
      check("rst_ctrl_norm", 32'(ctrl(0)), 32'(C_NORM));

      // Load-use on Rs
      cyc(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lu_rs_ctrl", 32'(ctrl(0)), 32'(C_LU));
      // Ex_Rd = 0 never stalls. This is also the cycle after the stall.
      cyc(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("lu_r0_ctrl", 32'(ctrl(0)), 32'(C_NORM));
      check("lu_stall1", 32'(stall_a), 1);
      // Rt match while the ID instruction does not read Rt
      cyc(1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
      check("lu_rt_unused", 32'(ctrl(0)), 32'(C_NORM));
      check("lu_stall_hold", 32'(stall_a), 1);
      // Rt match while the ID instruction reads Rt
      cyc(1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      check("lu_rt_ctrl", 32'(ctrl(0)), 32'(C_LU));
      // Taken branch together with a load-use condition
      cyc(1'b0, 1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("br_lu_ctrl", 32'(ctrl(0)), 32'(C_BRANCH));
      check("br_lu_stall_pre", 32'(stall_a), 2);
      idle();
      check("br_flush1", 32'(flush_a), 1);
      check("br_stall_same", 32'(stall_a), 2);

      // Memory wait for 3 cycles, then completion with a taken branch
      for (int k = 0; k < 3; k++) begin
         mwait();
         check("mw_ctrl", 32'(ctrl(0)), 32'(C_WAIT));
         check("mw_state", 32'(dbg_state[0]), (k == 0) ? 0 : 1);
         check("mw_stall", 32'(stall_a), 32'(2 + k));
      end
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      check("mw_exit_branch", 32'(ctrl(0)), 32'(C_BRANCH));
      check("mw_exit_state", 32'(dbg_state[0]), 1);
      check("mw_stall3", 32'(stall_a), 5);
      idle();
      check("mw_run_state", 32'(dbg_state[0]), 0);
      check("mw_flush2", 32'(flush_a), 2);
      check("mw_ctrl_norm", 32'(ctrl(0)), 32'(C_NORM));
      // A memory wait outranks a taken branch
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("mw_over_br", 32'(ctrl(0)), 32'(C_WAIT));
      idle();
      check("mw_over_br_flush", 32'(flush_a), 2);
      check("mw_over_br_stall", 32'(stall_a), 6);
      check("mw_short_no_to", 32'(mem_timeout[1]), 0);

      // Reset between groups
      cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("clr_ctrl", 32'(ctrl(0)), 32'(C_RESET));
      idle();
      check("clr_stall", 32'(stall_a), 0);
      check("clr_flush", 32'(flush_a), 0);

      // Watchdog: 6 wait cycles against MEM_TIMEOUT=4
      for (int k = 0; k < 6; k++) begin
         mwait();
         check("wd_flag", 32'(mem_timeout[1]), (k >= 4) ? 1 : 0);
         check("wd_default_flag", 32'(mem_timeout[0]), 0);
      end
      cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("wd_ready_ctrl", 32'(ctrl(1)), 32'(C_NORM));
      check("wd_flag_ready", 32'(mem_timeout[1]), 1);
      idle();
      check("wd_flag_sticky", 32'(mem_timeout[1]), 1);
      check("wd_stall6", 32'(stall_w), 6);
      check("wd_state_run", 32'(dbg_state[1]), 0);
      cyc(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle();
      check("wd_flag_clr", 32'(mem_timeout[1]), 0);

      // Saturation: 20 taken branches against CNT_W=4
      for (int k = 0; k < 20; k++) begin
         cyc(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
         if (k == 15) check("sat_flush15", 32'(flush_s), 15);
      end
      idle();
      check("sat_flush_hold", 32'(flush_s), 15);
      check("sat_flush_wide", 32'(flush_a), 20);
      check("sat_stall0", 32'(stall_s), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It drives the `*_en` and `*_clr_n` control ports of every pipeline register (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC enable. It resolves three hazard classes:
- load-use data hazards,
- taken-branch control hazards,
- multi-cycle data-memory waits.

It also keeps saturating performance counters and a memory-wait watchdog.

## Interface
Parameters:
- MEM_TIMEOUT, 64: consecutive memory-wait cycles after which `Mem_Timeout` is raised (range 1..65535).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- clr  in  1  reset, synchronous, active-high.
- Ex_Mem2reg  in  1  instruction in EX is a load.
- Ex_Rd  in  5  destination register of the instruction in EX.
- Id_Rs  in  5  source register 1 of the instruction in ID.
- Id_Rt  in  5  source register 2 of the instruction in ID.
- Id_UsesRt  in  1  ID instruction reads Rt.
- Ex_Branch_Taken  in  1  branch resolved taken in EX this cycle.
- Mem_Req  in  1  MEM stage is issuing a data-memory access.
- Mem_Ready  in  1  data memory completes the access this cycle.
- Pc_en  out  1  PC update enable.
- IfId_en, IfId_clr_n  out  1 each  IF_ID control.
- IdEx_en, IdEx_clr_n  out  1 each  ID_EX control.
- ExMem_en, ExMem_clr_n  out  1 each  EX_MEM control.
- MemWb_en, MemWb_clr_n  out  1 each  MEM_WB control.
- Stall_Cnt  out  CNT_W  cycles lost to load-use or memory stalls.
- Flush_Cnt  out  CNT_W  taken-branch flush events.
- Mem_Timeout  out  1  sticky watchdog flag.

## Operation
- Pipeline registers give `en=0` priority over `clr_n=0`. This block therefore drives `clr_n=1` whenever it drives `en=0`.
- FSM states:
  - RUN: no outstanding memory wait.
  - MWAIT: the previous cycle was a memory wait.
- Each cycle, the first matching case below applies:
  1. **clr=1.** All `*_en=1`, all `*_clr_n=0`, `Pc_en=1`. At the clock edge: state becomes RUN, both counters become 0, `Mem_Timeout` becomes 0, and the wait counter becomes 0.
  2. **Memory wait** (`Mem_Req=1` and `Mem_Ready=0`).
     - Outputs: `Pc_en=0`; IfId, IdEx and ExMem `en=0`; `MemWb_en=1`, `MemWb_clr_n=0` (a bubble into WB prevents a duplicate register write).
     - Next state MWAIT. Wait counter increments, saturating at MEM_TIMEOUT.
     - `Stall_Cnt` increments.
     - When the wait counter reaches MEM_TIMEOUT, `Mem_Timeout` is set and stays set until clr.
  3. **Taken branch** (`Ex_Branch_Taken=1`).
     - Outputs: `IfId_clr_n=0` and `IdEx_clr_n=0` with their `en=1`; all other registers pass; `Pc_en=1` (target load).
     - `Flush_Cnt` increments.
     - Branch beats load-use, because the dependent instruction in ID is being flushed.
  4. **Load-use.**
     - Condition: `Ex_Mem2reg=1`, `Ex_Rd!=0`, and either `Ex_Rd==Id_Rs` or (`Id_UsesRt=1` and `Ex_Rd==Id_Rt`).
     - Outputs: `Pc_en=0`, `IfId_en=0`, `IdEx_en=1` with `IdEx_clr_n=0` (bubble); EX_MEM and MEM_WB pass.
     - `Stall_Cnt` increments.
  5. **Normal.** All `en=1`, all `clr_n=1`, `Pc_en=1`.
- In cases 3–5 the next state is RUN and the wait counter clears to 0.
- MWAIT → RUN happens on the first cycle with `Mem_Ready=1` or `Mem_Req=0`. That cycle is evaluated by cases 3–5 normally, so a branch or load-use hazard in the same cycle is honoured.
- Counters saturate at all-ones and never wrap.
- A register number of 0 never causes a load-use stall.

## Timing
- All control outputs are combinational from the current inputs and `clr`, with zero-cycle latency. They take effect at the same posedge at which the pipeline registers sample.
- State, counters and `Mem_Timeout` update at posedge `clk`. `Stall_Cnt` and `Flush_Cnt` are visible one cycle after the event.
- Reset values:
  - `Stall_Cnt=0`, `Flush_Cnt=0`, `Mem_Timeout=0`, state RUN.
  - While `clr=1`, control outputs are as in case 1.
- A load-use stall lasts exactly 1 cycle. On the following cycle the load is in MEM, the condition clears, and the design requires no state for it.
- A memory wait lasts as many cycles as `Mem_Ready` stays low.
- Asserting `clr` during MWAIT aborts the wait at that edge. `Mem_Timeout` clears.

## Test plan
- **Reset:** hold `clr=1` for 2 cycles with random inputs → all `*_clr_n=0`, all `*_en=1`, `Pc_en=1`; after release, counters read 0 and `Mem_Timeout=0`.
- **Load-use:**
  - `Ex_Mem2reg=1`, `Ex_Rd=5`, `Id_Rs=5` → `Pc_en=0`, `IfId_en=0`, `IdEx_clr_n=0` for exactly 1 cycle; `Stall_Cnt=1`.
  - Repeat with `Ex_Rd=0` → no stall.
  - `Id_Rt=5` with `Id_UsesRt=0` → no stall.
- **Branch vs load-use:** `Ex_Branch_Taken=1` together with the load-use condition → IfId and IdEx clr_n=0, `Pc_en=1`; `Flush_Cnt=1`, `Stall_Cnt` unchanged.
- **Memory wait:** `Mem_Req=1`, `Mem_Ready=0` for 3 cycles, then `Mem_Ready=1`:
  - 3 cycles of freeze with `MemWb_clr_n=0`, then normal operation.
  - `Stall_Cnt=3`, state returns to RUN.
- **Watchdog:** with MEM_TIMEOUT=4, hold the memory wait for 6 cycles → `Mem_Timeout` rises after the 4th wait cycle and remains 1 after `Mem_Ready`, until `clr`.
- **Saturation:** with CNT_W=4, issue 20 branch flushes → `Flush_Cnt` holds at 15.
